// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, the default widths and the port index constants.
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT0    = 2'd1,
        GNT1    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// MEM_ARB_RR_EN defined: a collision goes to the port that was not served last; otherwise port1 wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_idx,
    output logic valid
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history; last_gnt is only consumed in round-robin builds.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        valid   = req0 | req1;
        gnt_idx = PORT1;
        if (req0 && !req1) begin
            gnt_idx = PORT0;
        end
`ifdef MEM_ARB_RR_EN
        else if (req0 && req1) begin
            gnt_idx = ~last_gnt;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one cache-line data memory between the icache (port0) and the dcache (port1).
// Build option MEM_ARB_RR_EN switches collision handling from fixed priority to round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       pick_idx, pick_valid;

    dmem_arb_pick u_pick (
        .req0     (m0_enable_i),
        .req1     (m1_enable_i),
        .last_gnt (last_gnt_q),
        .gnt_idx  (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= PORT0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Read data is broadcast; each requester qualifies it with its own ack.
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = (pick_idx == PORT1) ? GNT1 : GNT0;
                end
            end
            GNT0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                if (mem_ack_i) begin
                    m0_ack_o   = 1'b1;
                    last_gnt_d = PORT0;
                    state_d    = RELEASE;
                end else if (!m0_enable_i) begin
                    state_d = RELEASE;
                end
            end
            GNT1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                if (mem_ack_i) begin
                    m1_ack_o   = 1'b1;
                    last_gnt_d = PORT1;
                    state_d    = RELEASE;
                end else if (!m1_enable_i) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
